// File: rtl/esi_byte_stream_deserializer.sv
// Reassembles a little-endian framed byte stream into packed ESI messages.
// Frame-length errors are flagged with one-cycle pulses and counted in DropCount.
module esi_byte_stream_deserializer #(
   parameter int MSG_SIZE_BITS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ByteInValid,
   output logic                     ByteInReady,
   input  logic [7:0]               ByteIn,
   input  logic                     ByteInLast,
   output logic                     MsgOutValid,
   input  logic                     MsgOutReady,
   output logic [MSG_SIZE_BITS-1:0] MsgOut,
   output logic                     ErrShort,
   output logic                     ErrLong,
   output logic [15:0]              DropCount
);

   localparam int MSG_SIZE_BYTES     = (MSG_SIZE_BITS + 7) / 8;
   localparam int MSG_SIZE_BITS_DIFF = MSG_SIZE_BITS % 8;
   localparam int IDX_W              = (MSG_SIZE_BYTES > 1) ? $clog2(MSG_SIZE_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_SIZE_BYTES - 1);

   typedef enum logic [1:0] {
      COLLECT,
      HOLD,
      DRAIN
   } stateType;

   stateType         state;
   stateType         stateNext;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idxNext;
   logic             bufWrite;
   logic             errShortNext;
   logic             errLongNext;
   logic             dropInc;
   logic             byteFire;
   logic             msgFire;

   // Handshakes and frame bookkeeping. HOLD behaves like COLLECT at idx 0 once
   // the held message leaves, so one branch serves both states.
   always_comb begin
      stateNext    = state;
      idxNext      = idx;
      bufWrite     = 1'b0;
      errShortNext = 1'b0;
      errLongNext  = 1'b0;
      dropInc      = 1'b0;
      MsgOutValid  = (state == HOLD);
      ByteInReady  = (state == HOLD) ? MsgOutReady : 1'b1;
      byteFire     = ByteInValid && ByteInReady;
      msgFire      = MsgOutValid && MsgOutReady;
      case (state)
         DRAIN: begin
            if (byteFire && ByteInLast) begin
               stateNext = COLLECT;
               idxNext   = '0;
            end
         end
         default: begin
            if (msgFire) begin
               stateNext = COLLECT;
            end
            if (byteFire) begin
               bufWrite = 1'b1;
               if (idx == LAST_IDX) begin
                  idxNext = '0;
                  if (!ByteInLast) begin
                     errLongNext = 1'b1;
                     dropInc     = 1'b1;
                     stateNext   = DRAIN;
                  end else begin
                     stateNext = HOLD;
                  end
               end else if (ByteInLast) begin
                  errShortNext = 1'b1;
                  dropInc      = 1'b1;
                  idxNext      = '0;
                  stateNext    = COLLECT;
               end else begin
                  idxNext = idx + IDX_W'(1);
               end
            end
         end
      endcase
   end

   // Control state, error pulses and the saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         idx       <= '0;
         ErrShort  <= 1'b0;
         ErrLong   <= 1'b0;
         DropCount <= 16'd0;
      end else begin
         state    <= stateNext;
         idx      <= idxNext;
         ErrShort <= errShortNext;
         ErrLong  <= errLongNext;
         if (dropInc && (DropCount != 16'hFFFF)) begin
            DropCount <= DropCount + 16'd1;
         end
      end
   end

   // One register per message byte; a partial top byte keeps only its low bits.
   for (genvar k = 0; k < MSG_SIZE_BYTES; k++) begin : gByte
      if ((k == MSG_SIZE_BYTES - 1) && (MSG_SIZE_BITS_DIFF != 0)) begin : gPartial
         logic [MSG_SIZE_BITS_DIFF-1:0] byteReg;
         always_ff @(posedge clk) begin
            if (rst) begin
               byteReg <= '0;
            end else if (bufWrite && (idx == IDX_W'(k))) begin
               byteReg <= ByteIn[MSG_SIZE_BITS_DIFF-1:0];
            end
         end
         assign MsgOut[k*8 +: MSG_SIZE_BITS_DIFF] = byteReg;
      end else begin : gFull
         logic [7:0] byteReg;
         always_ff @(posedge clk) begin
            if (rst) begin
               byteReg <= '0;
            end else if (bufWrite && (idx == IDX_W'(k))) begin
               byteReg <= ByteIn;
            end
         end
         assign MsgOut[k*8 +: 8] = byteReg;
      end
   end

endmodule

// File: tb/tb_esi_byte_stream_deserializer.sv
// Bench for esi_byte_stream_deserializer at 20-, 32- and 8-bit message widths,
// checked cycle by cycle against a queue-based frame model.
module tb_esi_byte_stream_deserializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       byteValid;
   logic [7:0] byteData;
   logic       byteLast;
   logic       msgReady;
   logic [1:0] sel;

   logic [2:0]  inValid;
   logic [2:0]  inReady;
   logic [2:0]  outValid;
   logic [2:0]  errShort;
   logic [2:0]  errLong;
   logic [19:0] msg20;
   logic [31:0] msg32;
   logic [7:0]  msg8;
   logic [15:0] drop20;
   logic [15:0] drop32;
   logic [15:0] drop8;

   assign inValid = {byteValid && (sel == 2'd2), byteValid && (sel == 2'd1), byteValid && (sel == 2'd0)};

   esi_byte_stream_deserializer #(.MSG_SIZE_BITS(20)) u20 (
      .clk(clk), .rst(rst),
      .ByteInValid(inValid[0]), .ByteInReady(inReady[0]), .ByteIn(byteData), .ByteInLast(byteLast),
      .MsgOutValid(outValid[0]), .MsgOutReady(msgReady), .MsgOut(msg20),
      .ErrShort(errShort[0]), .ErrLong(errLong[0]), .DropCount(drop20)
   );

   esi_byte_stream_deserializer #(.MSG_SIZE_BITS(32)) u32 (
      .clk(clk), .rst(rst),
      .ByteInValid(inValid[1]), .ByteInReady(inReady[1]), .ByteIn(byteData), .ByteInLast(byteLast),
      .MsgOutValid(outValid[1]), .MsgOutReady(msgReady), .MsgOut(msg32),
      .ErrShort(errShort[1]), .ErrLong(errLong[1]), .DropCount(drop32)
   );

   esi_byte_stream_deserializer #(.MSG_SIZE_BITS(8)) u8 (
      .clk(clk), .rst(rst),
      .ByteInValid(inValid[2]), .ByteInReady(inReady[2]), .ByteIn(byteData), .ByteInLast(byteLast),
      .MsgOutValid(outValid[2]), .MsgOutReady(msgReady), .MsgOut(msg8),
      .ErrShort(errShort[2]), .ErrLong(errLong[2]), .DropCount(drop8)
   );

   logic        obsReady;
   logic        obsValid;
   logic        obsShort;
   logic        obsLong;
   logic [31:0] obsMsg;
   logic [15:0] obsDrop;

   // Route the selected instance's outputs to a common set of observation nets.
   always_comb begin
      obsReady = inReady[sel];
      obsValid = outValid[sel];
      obsShort = errShort[sel];
      obsLong  = errLong[sel];
      obsMsg   = 32'd0;
      obsDrop  = 16'd0;
      case (sel)
         2'd0: begin obsMsg = {12'd0, msg20}; obsDrop = drop20; end
         2'd1: begin obsMsg = msg32;          obsDrop = drop32; end
         default: begin obsMsg = {24'd0, msg8}; obsDrop = drop8; end
      endcase
   end

   int          compared = 0;
   int          mismatched = 0;

   int          nBits;
   int          nBytes;
   logic [7:0]  frame[$];
   bit          dropping;
   bit          mValid;
   logic [31:0] mMsg;
   bit          mShort;
   bit          mLong;
   int          mDrop;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] assembleFrame();
      logic [63:0] acc;
      acc = 64'd0;
      for (int k = 0; k < frame.size(); k++) begin
         acc = acc | (64'(frame[k]) << (8 * k));
      end
      acc = acc & ((64'd1 << nBits) - 64'd1);
      return acc[31:0];
   endfunction

   task automatic doReset(input logic [1:0] s);
      @(negedge clk);
      sel       = s;
      rst       = 1'b1;
      byteValid = 1'b0;
      byteData  = 8'd0;
      byteLast  = 1'b0;
      msgReady  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      case (s)
         2'd0: nBits = 20;
         2'd1: nBits = 32;
         default: nBits = 8;
      endcase
      nBytes   = (nBits + 7) / 8;
      frame.delete();
      dropping = 1'b0;
      mValid   = 1'b0;
      mMsg     = 32'd0;
      mShort   = 1'b0;
      mLong    = 1'b0;
      mDrop    = 0;
      check("reset_valid", {31'd0, obsValid}, 32'd0);
      check("reset_msg", obsMsg, 32'd0);
      check("reset_short", {31'd0, obsShort}, 32'd0);
      check("reset_long", {31'd0, obsLong}, 32'd0);
      check("reset_drop", {16'd0, obsDrop}, 32'd0);
   endtask

   task automatic checkOutput();
      check("msg_valid", {31'd0, obsValid}, {31'd0, mValid});
      check("byte_ready", {31'd0, obsReady}, {31'd0, (!mValid || msgReady)});
      check("err_short", {31'd0, obsShort}, {31'd0, mShort});
      check("err_long", {31'd0, obsLong}, {31'd0, mLong});
      check("drop_count", {16'd0, obsDrop}, 32'(mDrop));
      if (mValid) begin
         check("msg_data", obsMsg, mMsg);
      end
   endtask

   // One clock cycle: drive, check the current outputs, then advance the model.
   task automatic applyStimulus(input bit v, input logic [7:0] b, input bit l, input bit r);
      bit byteXfer;
      bit msgXfer;
      @(negedge clk);
      byteValid = v;
      byteData  = b;
      byteLast  = l;
      msgReady  = r;
      #1;
      checkOutput();
      byteXfer = v && (!mValid || r);
      msgXfer  = mValid && r;
      mShort   = 1'b0;
      mLong    = 1'b0;
      if (msgXfer) mValid = 1'b0;
      if (byteXfer) begin
         if (dropping) begin
            if (l) dropping = 1'b0;
         end else begin
            frame.push_back(b);
            if (frame.size() == nBytes) begin
               if (l) begin
                  mValid = 1'b1;
                  mMsg   = assembleFrame();
               end else begin
                  mLong    = 1'b1;
                  dropping = 1'b1;
                  if (mDrop < 65535) mDrop++;
               end
               frame.delete();
            end else if (l) begin
               mShort = 1'b1;
               if (mDrop < 65535) mDrop++;
               frame.delete();
            end
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      sel       = 2'd0;
      byteValid = 1'b0;
      byteData  = 8'd0;
      byteLast  = 1'b0;
      msgReady  = 1'b0;

      // 20-bit: good frame, short frame, long frame with recovery
      doReset(2'd0);
      applyStimulus(1, 8'h11, 0, 1);
      applyStimulus(1, 8'h22, 0, 1);
      applyStimulus(1, 8'hA3, 1, 1);
      repeat (3) applyStimulus(0, 8'h00, 0, 1);
      check("t1_dropcount", {16'd0, obsDrop}, 32'd0);
      applyStimulus(1, 8'h11, 0, 1);
      applyStimulus(1, 8'h22, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(1, 8'h01, 0, 1);
      applyStimulus(1, 8'h02, 0, 1);
      applyStimulus(1, 8'h03, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(1, 8'hAA, 0, 1);
      applyStimulus(1, 8'hBB, 0, 1);
      applyStimulus(1, 8'hCC, 0, 1);
      applyStimulus(1, 8'hDD, 1, 1);
      applyStimulus(1, 8'h44, 0, 1);
      applyStimulus(1, 8'h55, 0, 1);
      applyStimulus(1, 8'h06, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);

      // 32-bit backpressure, then simultaneous message and byte transfer
      doReset(2'd1);
      applyStimulus(1, 8'h01, 0, 0);
      applyStimulus(1, 8'h02, 0, 0);
      applyStimulus(1, 8'h03, 0, 0);
      applyStimulus(1, 8'h04, 1, 0);
      repeat (5) applyStimulus(1, 8'h05, 0, 0);
      applyStimulus(1, 8'h05, 0, 1);
      applyStimulus(1, 8'h06, 0, 1);
      applyStimulus(1, 8'h07, 0, 1);
      applyStimulus(1, 8'h08, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);

      // 8-bit back-to-back single-byte frames and a long frame
      doReset(2'd2);
      applyStimulus(1, 8'h10, 1, 1);
      applyStimulus(1, 8'h11, 1, 1);
      applyStimulus(1, 8'h12, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);
      applyStimulus(1, 8'h33, 0, 1);
      applyStimulus(1, 8'h34, 1, 1);
      applyStimulus(1, 8'h35, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);

      // 32-bit reset in the middle of a frame
      doReset(2'd1);
      applyStimulus(1, 8'h01, 0, 1);
      applyStimulus(1, 8'h02, 0, 1);
      doReset(2'd1);
      applyStimulus(1, 8'hDE, 0, 1);
      applyStimulus(1, 8'hAD, 0, 1);
      applyStimulus(1, 8'hBE, 0, 1);
      applyStimulus(1, 8'hEF, 1, 1);
      repeat (2) applyStimulus(0, 8'h00, 0, 1);

      // Randomized traffic on every width, mostly well-formed frames
      for (int s = 0; s < 3; s++) begin
         doReset(2'(s));
         repeat (400) begin
            bit v;
            bit l;
            bit r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) l = 1'($urandom_range(0, 1));
            else l = ((int'(frame.size()) + 1) == nBytes);
            applyStimulus(v, 8'($urandom), l, r);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
